// File: rtl/boot_loader.sv
// boot_loader: instruction-memory boot controller.
// Receives a program image over a UART byte stream (LEN_LO, LEN_HI, 4*N data bytes,
// 8-bit additive checksum), packs the data bytes into little-endian 32-bit words and
// writes them to consecutive word addresses while holding the CPU stalled.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     one-cycle boot request (taken only in idle or error)
//   rx_valid  one-cycle strobe, rx_data holds a received byte
//   rx_data   received byte
//   cpu_hold  high stalls the CPU
//   wr_en     one-cycle instruction-memory write strobe
//   wr_addr   word-aligned byte address of the write
//   wr_data   word to write
//   done      one-cycle pulse after a verified load
//   err       high after a failed load until the next start
module boot_loader #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        cpu_hold,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        err
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum, StErr} state_t;

    state_t        r_state, w_state_d;
    logic [15:0]   r_len,   w_len_d;
    logic [IW-1:0] r_widx,  w_widx_d;
    logic [1:0]    r_bsel,  w_bsel_d;
    // Only the first three bytes of a word are buffered; the fourth comes straight
    // from rx_data in the cycle that triggers the write.
    logic [23:0]   r_asm,   w_asm_d;
    logic [7:0]    r_csum,  w_csum_d;
    logic [TW-1:0] r_tmo,   w_tmo_d;

    logic          r_hold,  w_hold_d;
    logic          r_wr_en, w_wr_en_d;
    logic [31:0]   r_wr_addr, w_wr_addr_d;
    logic [31:0]   r_wr_data, w_wr_data_d;
    logic          r_done,  w_done_d;
    logic          r_err,   w_err_d;

    logic [15:0]   w_len_full;
    logic          w_bad_len;
    logic          w_last_word;
    logic          w_expire;

    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_bad_len   = (w_len_full == 16'd0) || (32'(w_len_full) > DEPTH);
    assign w_last_word = (16'(r_widx) == (r_len - 16'd1));
    // Expiry fires on the TIMEOUT-th consecutive cycle without a byte.
    assign w_expire    = !rx_valid && (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_state_d   = r_state;
        w_len_d     = r_len;
        w_widx_d    = r_widx;
        w_bsel_d    = r_bsel;
        w_asm_d     = r_asm;
        w_csum_d    = r_csum;
        w_tmo_d     = r_tmo;
        w_wr_en_d   = 1'b0;
        w_wr_addr_d = r_wr_addr;
        w_wr_data_d = r_wr_data;
        w_done_d    = 1'b0;

        unique case (r_state)
            StIdle, StErr: begin
                if (start) begin
                    w_state_d = StLen0;
                    w_widx_d  = '0;
                    w_bsel_d  = '0;
                    w_csum_d  = '0;
                    w_tmo_d   = '0;
                end
            end
            StLen0, StLen1, StData, StCsum: begin
                if (rx_valid) begin
                    w_tmo_d = '0;
                    unique case (r_state)
                        StLen0: begin
                            w_len_d[7:0] = rx_data;
                            w_state_d    = StLen1;
                        end
                        StLen1: begin
                            w_len_d[15:8] = rx_data;
                            w_state_d     = w_bad_len ? StErr : StData;
                        end
                        StData: begin
                            w_asm_d  = {rx_data, r_asm[23:8]};
                            w_csum_d = r_csum + rx_data;
                            w_bsel_d = r_bsel + 2'd1;
                            if (r_bsel == 2'd3) begin
                                w_wr_en_d   = 1'b1;
                                w_wr_addr_d = 32'({r_widx, 2'b00});
                                w_wr_data_d = {rx_data, r_asm};
                                // Index stays put after the last word so N=DEPTH never wraps.
                                if (w_last_word) begin
                                    w_state_d = StCsum;
                                end else begin
                                    w_widx_d = r_widx + IW'(1);
                                end
                            end
                        end
                        default: begin
                            if (rx_data == r_csum) begin
                                w_state_d = StIdle;
                                w_done_d  = 1'b1;
                            end else begin
                                w_state_d = StErr;
                            end
                        end
                    endcase
                end else if (w_expire) begin
                    w_state_d = StErr;
                end else begin
                    w_tmo_d = r_tmo + TW'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_hold_d = (w_state_d != StIdle);
        w_err_d  = (w_state_d == StErr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_len     <= '0;
            r_widx    <= '0;
            r_bsel    <= '0;
            r_asm     <= '0;
            r_csum    <= '0;
            r_tmo     <= '0;
            r_hold    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_len     <= w_len_d;
            r_widx    <= w_widx_d;
            r_bsel    <= w_bsel_d;
            r_asm     <= w_asm_d;
            r_csum    <= w_csum_d;
            r_tmo     <= w_tmo_d;
            r_hold    <= w_hold_d;
            r_wr_en   <= w_wr_en_d;
            r_wr_addr <= w_wr_addr_d;
            r_wr_data <= w_wr_data_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
        end
    end

    assign cpu_hold = r_hold;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed bench for boot_loader with a byte-position reference model
// and a per-cycle output compare.
module tb_boot_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned TMO   = 40;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        cpu_hold;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic        err;

    boot_loader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .cpu_hold (cpu_hold),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position within the image stream rather than a state machine.
    logic        m_active, m_err, m_hold;
    int          m_pos, m_n, m_idle;
    logic [7:0]  m_sum;
    logic [31:0] m_word;
    logic        e_wr_en, e_done;
    logic [31:0] e_addr, e_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0; m_err <= 1'b0; m_hold <= 1'b0;
            m_pos <= 0; m_n <= 0; m_idle <= 0; m_sum <= 8'h00; m_word <= '0;
            e_wr_en <= 1'b0; e_done <= 1'b0; e_addr <= '0; e_data <= '0;
        end else begin : model_step
            logic        act, er, hd, we, dn;
            int          pos, n, idl, j;
            logic [7:0]  sum;
            logic [31:0] wd, ad, dt;
            act = m_active; er = m_err; hd = m_hold;
            pos = m_pos; n = m_n; idl = m_idle; sum = m_sum; wd = m_word;
            we = 1'b0; dn = 1'b0; ad = e_addr; dt = e_data;
            if (!act) begin
                if (start) begin
                    act = 1'b1; er = 1'b0; hd = 1'b1; pos = 0; sum = 8'h00; idl = 0;
                end
            end else if (rx_valid) begin
                idl = 0;
                if (pos == 0) begin
                    n = int'(rx_data);
                end else if (pos == 1) begin
                    n = n + 256 * int'(rx_data);
                    if (n == 0 || n > int'(DEPTH)) begin act = 1'b0; er = 1'b1; end
                end else if (pos < 2 + 4 * n) begin
                    j = (pos - 2) % 4;
                    wd[8*j +: 8] = rx_data;
                    sum = sum + rx_data;
                    if (j == 3) begin
                        we = 1'b1;
                        ad = 32'(4 * ((pos - 2) / 4));
                        dt = wd;
                    end
                end else if (rx_data == sum) begin
                    act = 1'b0; hd = 1'b0; dn = 1'b1;
                end else begin
                    act = 1'b0; er = 1'b1;
                end
                pos++;
            end else begin
                idl++;
                if (idl >= int'(TMO)) begin act = 1'b0; er = 1'b1; end
            end
            m_active <= act; m_err <= er; m_hold <= hd;
            m_pos <= pos; m_n <= n; m_idle <= idl; m_sum <= sum; m_word <= wd;
            e_wr_en <= we; e_done <= dn; e_addr <= ad; e_data <= dt;
        end
    end

    // Per-cycle compare plus capture of writes into a shadow memory.
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] mem [DEPTH];
    logic [31:0] last_addr = '0;

    always @(posedge clk) begin
        #1;
        chk("cpu_hold", 32'(cpu_hold), 32'(m_hold));
        chk("wr_en", 32'(wr_en), 32'(e_wr_en));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(m_err));
        if (e_wr_en) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        if (wr_en === 1'b1) begin
            wr_cnt++;
            mem[wr_addr[9:2]] = wr_data;
            last_addr = wr_addr;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic drive(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; rx_valid = v; rx_data = d;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b0, 1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    initial begin
        int          w0;
        int          d0;
        logic [7:0]  cs;
        logic [31:0] wv;

        #1 reset = 1'b0;
        idle(3);
        #1;
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_addr", wr_addr, 32'h0);
        chk("rst_data", wr_data, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk) reset = 1'b1;
        idle(2);

        // Two-word image; checksum 0x00+0x00+0x01+0x3C+0x08 = 0x45.
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        send(8'h02); send(8'h00);
        send_word(32'h3C01_0000);
        send_word(32'h0000_0008);
        send(8'h45);
        idle(2); settle();
        chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
        chk("t1_mem0", mem[0], 32'h3C01_0000);
        chk("t1_mem1", mem[1], 32'h0000_0008);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'h0);
        chk("t1_err", 32'(err), 32'h0);

        // Bad lengths: 0 and DEPTH+1.
        w0 = wr_cnt;
        drive(1'b1, 1'b0, 8'h00);
        send(8'h00); send(8'h00);
        idle(1); settle();
        chk("t2_len0_err", 32'(err), 32'h1);
        chk("t2_len0_hold", 32'(cpu_hold), 32'h1);
        drive(1'b1, 1'b0, 8'h00);
        send(8'h01); send(8'h01);
        idle(1); settle();
        chk("t2_len257_err", 32'(err), 32'h1);
        chk("t2_no_writes", 32'(wr_cnt - w0), 32'd0);
        d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        idle(1); settle();
        chk("t2_err_cleared", 32'(err), 32'h0);
        send(8'h01); send(8'h00);
        send_word(32'h4433_2211);
        send(8'hAA);
        idle(2); settle();
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_mem0", mem[0], 32'h4433_2211);
        chk("t2_err", 32'(err), 32'h0);

        // Checksum mismatch: expected 0x01, sent 0x00.
        w0 = wr_cnt; d0 = done_cnt;
        drive(1'b1, 1'b0, 8'h00);
        send(8'h01); send(8'h00);
        send_word(32'h0000_0001);
        send(8'h00);
        idle(2); settle();
        chk("t3_writes", 32'(wr_cnt - w0), 32'd1);
        chk("t3_mem0", mem[0], 32'h0000_0001);
        chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_hold", 32'(cpu_hold), 32'h1);

        // Timeout waiting for LEN_HI.
        drive(1'b1, 1'b0, 8'h00);
        send(8'h05);
        idle(TMO - 1); settle();
        chk("t4_len1_before", 32'(err), 32'h0);
        idle(1); settle();
        chk("t4_len1_expire", 32'(err), 32'h1);
        // Byte after TMO-1 idle cycles is accepted; timeout then hits in data phase.
        drive(1'b1, 1'b0, 8'h00);
        send(8'h01);
        idle(TMO - 1);
        send(8'h00);
        idle(TMO - 1); settle();
        chk("t4_data_before", 32'(err), 32'h0);
        idle(1); settle();
        chk("t4_data_expire", 32'(err), 32'h1);
        // Timeout straight after start.
        drive(1'b1, 1'b0, 8'h00);
        idle(TMO - 1); settle();
        chk("t4_len0_before", 32'(err), 32'h0);
        idle(1); settle();
        chk("t4_len0_expire", 32'(err), 32'h1);

        // Asynchronous reset after five data bytes of a four-word load.
        w0 = wr_cnt;
        drive(1'b1, 1'b0, 8'h00);
        send(8'h04); send(8'h00);
        for (int i = 1; i <= 5; i++) send(8'(i));
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t5_one_write", 32'(wr_cnt - w0), 32'd1);
        chk("t5_hold", 32'(cpu_hold), 32'h0);
        chk("t5_wr_en", 32'(wr_en), 32'h0);
        chk("t5_addr", wr_addr, 32'h0);
        chk("t5_data", wr_data, 32'h0);
        chk("t5_done", 32'(done), 32'h0);
        chk("t5_err", 32'(err), 32'h0);
        @(negedge clk) reset = 1'b1;
        w0 = wr_cnt;
        for (int i = 6; i <= 16; i++) send(8'(i));
        idle(2); settle();
        chk("t5_no_more_writes", 32'(wr_cnt - w0), 32'd0);
        chk("t5_hold_after", 32'(cpu_hold), 32'h0);

        // Full-depth load, back-to-back bytes.
        w0 = wr_cnt; d0 = done_cnt; cs = 8'h00;
        drive(1'b1, 1'b0, 8'h00);
        send(8'h00); send(8'h01);
        for (int k = 0; k < int'(DEPTH); k++) begin
            wv = 32'hC0DE_0000 + 32'(k);
            send_word(wv);
            cs = cs + wv[7:0] + wv[15:8] + wv[23:16] + wv[31:24];
        end
        send(cs);
        idle(2); settle();
        chk("t6_writes", 32'(wr_cnt - w0), 32'd256);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_last_addr", last_addr, 32'h0000_03FC);
        chk("t6_hold", 32'(cpu_hold), 32'h0);
        chk("t6_err", 32'(err), 32'h0);
        for (int k = 0; k < int'(DEPTH); k++) begin
            chk("t6_mem", mem[k], 32'hC0DE_0000 + 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
